// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit that owns the HI/LO registers.
// Shift-add multiply and restoring divide run on magnitudes; signs are fixed up in one final cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] crs,
   input  logic [WIDTH-1:0] crt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        cnt_reg;
   logic [2*WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]     addend_reg;
   logic [WIDTH-1:0]     a_orig_reg;
   logic                 is_div_reg;
   logic                 neg_lo_reg;
   logic                 neg_hi_reg;
   logic                 zero_div_reg;
   logic [WIDTH-1:0]     hi_reg, lo_reg;
   logic                 busy_reg, done_reg, dbz_reg;

   logic                 accept, iter_start, mt_start, last_iter;
   logic                 a_neg, b_neg;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH-1:0]     rem_diff;
   logic                 fits;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   prod_fixed;
   logic [WIDTH-1:0]     quo_fixed, rem_fixed;

   assign accept     = (state_reg == IDLE) && start;
   assign iter_start = accept && !md_op[2];
   assign mt_start   = accept && (md_op[2:1] == 2'b10);
   assign last_iter  = (cnt_reg == CW'(WIDTH - 1));

   // md_op[0] selects the signed variant for both multiply and divide
   assign a_neg = md_op[0] & crs[WIDTH-1];
   assign b_neg = md_op[0] & crt[WIDTH-1];
   assign a_mag = a_neg ? -crs : crs;
   assign b_mag = b_neg ? -crt : crt;

   // Multiply: upper half accumulates, whole pair shifts right one bit per cycle
   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                     (acc_reg[0] ? {1'b0, addend_reg} : '0);
   assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

   // Divide: the shifted remainder needs one extra bit before the trial subtract
   assign rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
   assign fits     = rem_sh >= {1'b0, addend_reg};
   assign rem_diff = rem_sh[WIDTH-1:0] - addend_reg;
   assign div_next = {(fits ? rem_diff : rem_sh[WIDTH-1:0]), acc_reg[WIDTH-2:0], fits};

   assign prod_fixed = neg_lo_reg ? -acc_reg : acc_reg;
   assign quo_fixed  = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
   assign rem_fixed  = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (iter_start) state_next = RUN;
         RUN:     if (last_iter)  state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         acc_reg      <= '0;
         addend_reg   <= '0;
         a_orig_reg   <= '0;
         is_div_reg   <= 1'b0;
         neg_lo_reg   <= 1'b0;
         neg_hi_reg   <= 1'b0;
         zero_div_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         dbz_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (iter_start) begin
                  cnt_reg      <= '0;
                  is_div_reg   <= md_op[1];
                  neg_lo_reg   <= a_neg ^ b_neg;
                  neg_hi_reg   <= a_neg;
                  zero_div_reg <= md_op[1] && (crt == '0);
                  a_orig_reg   <= crs;
                  busy_reg     <= 1'b1;
                  dbz_reg      <= 1'b0;
                  // Multiply keeps the multiplier in the low half; divide keeps the dividend there
                  if (md_op[1]) begin
                     acc_reg    <= {{WIDTH{1'b0}}, a_mag};
                     addend_reg <= b_mag;
                  end else begin
                     acc_reg    <= {{WIDTH{1'b0}}, b_mag};
                     addend_reg <= a_mag;
                  end
               end else if (mt_start) begin
                  if (md_op[0]) lo_reg <= crs;
                  else          hi_reg <= crs;
                  done_reg <= 1'b1;
                  dbz_reg  <= 1'b0;
               end
            end
            RUN: begin
               acc_reg <= is_div_reg ? div_next : mul_next;
               cnt_reg <= cnt_reg + CW'(1);
            end
            FIX: begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
               cnt_reg  <= '0;
               if (is_div_reg && zero_div_reg) begin
                  hi_reg  <= a_orig_reg;
                  lo_reg  <= '1;
                  dbz_reg <= 1'b1;
               end else if (is_div_reg) begin
                  hi_reg <= rem_fixed;
                  lo_reg <= quo_fixed;
               end else begin
                  hi_reg <= prod_fixed[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_fixed[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign hi          = hi_reg;
   assign lo          = lo_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed test of mult_div_unit: arithmetic results, timing of busy/done,
// divide-by-zero flag, HI/LO moves, ignored starts and asynchronous reset.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'b000;
   logic [31:0] crs = '0;
   logic [31:0] crt = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   localparam logic [2:0] OP_MULTU = 3'b000, OP_MULT = 3'b001, OP_DIVU = 3'b010,
                          OP_DIV = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101, OP_NOP = 3'b110;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .crs(crs), .crt(crt),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, obs);
      end
   endtask

   // Drive a request for one cycle; returns at accepting edge + 1 with inputs scrambled
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; md_op = op; crs = a; crt = b;
      @(posedge clk); #1;
      start = 1'b0; crs = $urandom; crt = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_iter(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      issue(op, a, b);
      wait_done(n);
      check({tag, " busy_cycles"}, 32'(n), 32'd33);
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      #23;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      check("reset dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      do_iter("multu ffff*ffff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      @(posedge clk); #1;
      check("multu done single pulse", 32'(done), 32'd0);

      do_iter("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
      do_iter("mult 8000*8000", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      do_iter("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      do_iter("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      do_iter("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      do_iter("div 8000/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      do_iter("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
      check("divu 5/0 dbz", 32'(div_by_zero), 32'd1);

      issue(OP_NOP, 32'hAAAA, 32'hBBBB);
      check("nop done", 32'(done), 32'd0);
      check("nop busy", 32'(busy), 32'd0);
      check("nop dbz kept", 32'(div_by_zero), 32'd1);
      check("nop hi kept", hi, 32'd5);

      issue(OP_MULTU, 32'd3, 32'd4);
      check("multu clears dbz", 32'(div_by_zero), 32'd0);
      wait_done(cyc);
      check("multu 3*4 lo", lo, 32'd12);
      check("multu 3*4 hi", hi, 32'd0);

      issue(OP_MTHI, 32'h1234, 32'd0);
      check("mthi done", 32'(done), 32'd1);
      check("mthi busy", 32'(busy), 32'd0);
      check("mthi hi", hi, 32'h1234);
      @(posedge clk); #1;
      check("mthi done pulse", 32'(done), 32'd0);
      issue(OP_MTLO, 32'h5678, 32'd0);
      check("mtlo done", 32'(done), 32'd1);
      check("mtlo busy", 32'(busy), 32'd0);
      check("mtlo lo", lo, 32'h5678);
      check("mtlo hi kept", hi, 32'h1234);
      @(posedge clk); #1;
      check("mtlo done pulse", 32'(done), 32'd0);

      issue(OP_MULTU, 32'd6, 32'd7);
      check("midrun accept busy", 32'(busy), 32'd1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      start = 1'b1; md_op = OP_MTHI; crs = 32'hDEAD;
      @(posedge clk); #1;
      start = 1'b0;
      check("midrun start hi held", hi, 32'h1234);
      check("midrun start lo held", lo, 32'h5678);
      check("midrun still busy", 32'(busy), 32'd1);
      wait_done(cyc);
      check("midrun done", 32'(done), 32'd1);
      check("midrun result hi", hi, 32'd0);
      check("midrun result lo", lo, 32'd42);

      issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
      check("back2back accepted", 32'(busy), 32'd1);
      wait_done(cyc);
      check("back2back cycles", 32'(cyc), 32'd33);
      check("back2back hi", hi, 32'd1);
      check("back2back lo", lo, 32'hFFFFFFFE);

      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (14) @(posedge clk);
      #2;
      check("pre-reset busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("async reset busy", 32'(busy), 32'd0);
      check("async reset done", 32'(done), 32'd0);
      check("async reset hi", hi, 32'd0);
      check("async reset lo", lo, 32'd0);
      check("async reset dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      do_iter("post-reset multu 3*4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
